// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined WIDTH x WIDTH multiplier, signed or unsigned per operation.
// The Baugh-Wooley partial-product matrix is reduced by a carry-save (3:2) tree.
// Register stages are: operand capture, reduced sum/carry rows, CPA result, and the output hold register.
// A single stall (out_valid && !out_ready) freezes every stage at once.
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int P  = 2 * WIDTH;
  localparam int NR = WIDTH + 1;   // WIDTH partial-product rows plus one row of signed-mode constants
  localparam int NA = NR + 2;      // slack so unrolled index arithmetic stays in range

  logic             stall;
  logic [3:1]       vld_pipe;
  logic [WIDTH-1:0] a1, b1;
  logic             s1;
  logic [P-1:0]     sum2, car2, sum_d, car_d, p3;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Partial products with Baugh-Wooley correction, then carry-save reduction down to two rows
  always_comb begin : wallace
    logic [P-1:0] r [NA];
    logic [P-1:0] t [NA];
    logic         pb;
    int           n, k;
    for (int i = 0; i < NA; i++) begin
      r[i] = '0;
      t[i] = '0;
    end
    pb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pb = a1[j] & b1[i];
        // In signed mode, invert the bits that pair exactly one sign bit with a magnitude bit
        if (s1 && ((i == WIDTH-1) != (j == WIDTH-1)))
          pb = ~pb;
        r[i] = r[i] | ({{(P-1){1'b0}}, pb} << (i + j));
      end
    end
    // Baugh-Wooley constants: +2^WIDTH and +2^(2*WIDTH-1), taken modulo 2^(2*WIDTH)
    r[WIDTH] = s1 ? ((P'(1) << WIDTH) | (P'(1) << (P-1))) : '0;
    n = NR;
    for (int lv = 0; lv < NR; lv++) begin
      if (n > 2) begin
        k = 0;
        for (int g = 0; g < NR; g += 3) begin
          if (g + 2 < n) begin
            t[k]   = r[g] ^ r[g+1] ^ r[g+2];
            t[k+1] = ((r[g] & r[g+1]) | (r[g] & r[g+2]) | (r[g+1] & r[g+2])) << 1;
            k      = k + 2;
          end else if (g < n) begin
            t[k] = r[g];
            k    = k + 1;
            if (g + 1 < n) begin
              t[k] = r[g+1];
              k    = k + 1;
            end
          end
        end
        for (int i = 0; i < NA; i++)
          r[i] = (i < k) ? t[i] : '0;
        n = k;
      end
    end
    sum_d = r[0];
    car_d = r[1];
  end

  // Pipeline registers: all stages advance together unless the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      a1        <= '0;
      b1        <= '0;
      s1        <= 1'b0;
      sum2      <= '0;
      car2      <= '0;
      p3        <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else if (!stall) begin
      vld_pipe  <= {vld_pipe[2:1], in_valid};
      a1        <= a;
      b1        <= b;
      s1        <= is_signed;
      sum2      <= sum_d;
      car2      <= car_d;
      p3        <= sum2 + car2;
      out_valid <= vld_pipe[3];
      product   <= p3;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: table vectors, back-pressure, reset and random traffic
// for an 8-bit wallace_mult_pipe, scored against an arithmetic reference.
module tb_wallace_mult_pipe;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] product;

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } ent_t;

  vec_t        tbl [12];
  ent_t        q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pops = 0;
  bit          took = 1'b0;
  bit          lat_chk = 1'b0;
  bit          bp_mode = 1'b0;
  logic [15:0] exp_in = '0;

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint lx, ly;
    lx = s ? longint'($signed(x)) : longint'(x);
    ly = s ? longint'($signed(y)) : longint'(y);
    return 16'(lx * ly);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: score transfers at the negedge, then advance past the posedge
  task automatic step();
    ent_t e;
    @(negedge clk);
    took = in_valid && in_ready;
    if (out_valid && out_ready) begin
      pops++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious: product %h with nothing outstanding (cycle %0d)", product, cyc);
      end else begin
        e = q.pop_front();
        chk("product", 32'(product), 32'(e.exp));
        if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd3);
      end
    end
    if (took) q.push_back('{exp_in, cyc + 1});
    @(posedge clk);
    cyc++;
    #1;
    if (bp_mode) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic sg, input logic [15:0] ex);
    int n;
    n = 0;
    in_valid = 1'b1; a = ia; b = ib; is_signed = sg; exp_in = ex;
    do begin
      step();
      n++;
    end while (!took && n < 200);
    if (!took) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int p0;
    logic [7:0] ra, rb;
    logic       rs;
    tbl[0]  = '{8'hC8, 8'h64, 1'b0, 16'h4E20};
    tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[2]  = '{8'h00, 8'h4D, 1'b0, 16'h0000};
    tbl[3]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
    tbl[4]  = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    tbl[5]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[6]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    tbl[7]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[8]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    tbl[9]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    tbl[10] = '{8'hF8, 8'hF8, 1'b1, 16'h0040};
    tbl[11] = '{8'hFF, 8'h07, 1'b1, 16'hFFF9};

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    // Table vectors back-to-back, mixed modes, fixed latency
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);
    drain();

    // Back-pressure: hold the first result for 5 cycles
    lat_chk = 1'b0;
    issue(8'd200, 8'd100, 1'b0, 16'h4E20);
    issue(8'd255, 8'd255, 1'b0, 16'hFE01);
    issue(8'd0, 8'd77, 1'b0, 16'h0000);
    in_valid = 1'b0;
    wait_valid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_product", 32'(product), 32'h4E20);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 3; i++) step();
    chk("release_pops", 32'(pops - p0), 32'd3);
    chk("release_empty", 32'(q.size()), 32'd0);

    // Reset mid-operation with a result held at the output
    issue(8'd9, 8'd11, 1'b0, 16'd99);
    issue(8'd12, 8'd13, 1'b0, 16'd156);
    issue(8'hFE, 8'd3, 1'b1, 16'hFFFA);
    in_valid = 1'b0;
    wait_valid();
    out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_product", 32'(product), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("no_stale", 32'(out_valid), 32'd0);
    lat_chk = 1'b1;
    issue(8'd3, 8'd5, 1'b0, 16'd15);
    drain();

    // Random traffic with random back-pressure and idle cycles
    lat_chk = 1'b0;
    bp_mode = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end else begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rs = 1'($urandom);
        issue(ra, rb, rs, model(ra, rb, rs));
      end
    end
    bp_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wallace_mult_pipe.md
# wallace_mult_pipe

Parametrised, pipelined Wallace-tree multiplier with a valid/ready handshake and per-operation signed/unsigned selection. It takes two WIDTH-bit operands and returns a 2*WIDTH-bit product after a fixed three-stage pipeline, sustaining one operation per clock when not back-pressured. It is the arithmetic core for the datapath blocks that follow the combinational 4x4 multiplier and replaces it wherever throughput, wider operands or signed data are needed.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk at the integration level.
- in_valid  input  1  a, b and is_signed hold a valid operation.
- in_ready  output  1  the block accepts the operation this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with the operands.
- out_valid  output  1  product holds a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- product  output  2*WIDTH  a*b, exact with no truncation or saturation, interpreted per the captured is_signed.

## Operation
- Transfer rules: an input transfer occurs on a rising edge with in_valid && in_ready; an output transfer occurs with out_valid && out_ready.
- Pipeline:
  - S1 registers a, b, is_signed and a valid bit.
  - S2 generates the partial products from the S1 operands, reduces them with a Wallace tree of full adders (3:2) and half adders (2:2) to two rows, and registers the sum and carry vectors (2*WIDTH each) plus a valid bit.
  - S3 adds the two rows with a carry-propagate adder and registers product and out_valid.
- Signed mode: implemented by Baugh-Wooley partial-product correction, so the tree is shared by both modes with no separate path. The result is the two's complement product, which is exact in 2*WIDTH bits. For example, with WIDTH=4, (-8)*(-8) = 64 fits.
- Stall: stall = out_valid && !out_ready. When stall is high, every stage register, including product and the valid bits, holds its value. When stall is low, all stages advance together.
- Handshake outputs:
  - in_ready = !stall, driven combinationally from out_valid and out_ready.
  - in_ready does not depend on in_valid.
- Bubbles: empty stages are not collapsed during a stall. They advance only when the stall clears.
- Handshake obligations:
  - product and out_valid stay stable while out_valid && !out_ready.
  - The block never drops or duplicates an accepted operation.
  - Results leave in acceptance order.
- Each operation carries its own is_signed through the stages, so mixed modes may be issued back-to-back.
- Reset (rst_n low): asynchronously clears
  - all valid bits, so out_valid = 0 and the pipeline is empty;
  - product = 0;
  - all data registers = 0.
  - in_ready = 1 while in reset and immediately after.
- Reset mid-operation discards every in-flight operation. No result appears for any operation accepted before the reset.

## Timing
- Latency:
  - An operation accepted at edge k, with no stall, presents out_valid = 1 and its product after edge k+3.
  - Each stall cycle adds exactly one cycle of latency.
- Throughput is 1 operation per cycle with out_ready held high. Four operations are in flight at most: S1, S2, S3 and the held output.
- The first valid product follows reset release by at least 3 cycles.
- Output timing: out_valid and product are registered outputs. in_ready is the only combinational output.
- Critical path: Wallace reduction in S2, or the CPA in S3. Depth is O(log WIDTH) adder levels in S2 and one 2*WIDTH adder in S3.
- Simultaneous events:
  - An output transfer and an input transfer may occur on the same edge while out_valid = 1 and out_ready = 1.
  - rst_n asserted on the same edge as a transfer wins, and the transfer is lost.

## Test plan
- Unsigned maximum, WIDTH=4: issue a=15, b=15, is_signed=0 with out_ready=1. product=0x00E1 (225) appears exactly 3 cycles after acceptance, and out_valid pulses for one cycle.
- Signed corner cases, WIDTH=4, issued back-to-back:
  - (-8)*(-8) -> 0x40.
  - (-1)*7 -> 0xF9.
  - 7*(-8) -> 0xC8.
  - Then unsigned 0xF*0x1 -> 0x0F.
  - Results arrive on consecutive cycles in order.
- Exhaustive WIDTH=4 and random WIDTH=8/16: run all 2*256 (operand, mode) combinations for WIDTH=4, and 10k random operations for WIDTH=8/16 with random in_valid and out_ready. The result must match a reference model, with no loss, duplication or reordering.
- Back-pressure, WIDTH=8: stream 200*100 (0x4E20), 255*255 (0xFE01) and 0*77 (0x0000), and hold out_ready=0 for 5 cycles once out_valid rises.
  - product holds 0x4E20 and in_ready=0 throughout the hold.
  - After release, the three results emerge in order, one per cycle.
- Reset mid-operation: accept 3 operations, assert rst_n low for 1 cycle while they are in flight.
  - out_valid=0 and product=0 immediately, asynchronously.
  - No stale result ever appears.
  - A new 3*5 issued after reset returns 15 after 3 cycles.
- Zero and identity, WIDTH=8, signed: 0*(-128) -> 0x0000; 1*(-128) -> 0xFF80; (-128)*(-128) -> 0x4000.
